// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high hex segment
// patterns ({g,f,e,d,c,b,a}, bit0 = a) and the nibble decode helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = '0;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = hex_to_seg(i_nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, per-frame value
// snapshot, leading-zero blanking, brightness PWM and anti-ghost anode gap.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int PRESCALE_W     = 14,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0,
    parameter int BLANK_LZ       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [3:0]              brightness,
    output logic [6:0]              disp_seg,
    output logic                    disp_dp,
    output logic [N_DIGITS-1:0]     disp_an,
    output logic                    frame_start
);

    localparam int               IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic             SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic             AN_INV   = (AN_ACTIVE_LOW != 0);

    logic [PRESCALE_W-1:0] r_prescaler;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic                  r_frame_start;
    logic [6:0]            r_disp_seg;
    logic                  r_disp_dp;
    logic [N_DIGITS-1:0]   r_disp_an;

    logic                  w_tick;
    logic                  w_pwm_on;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_en_sel;
    logic                  w_nz_sel;
    logic                  w_blank;
    logic [6:0]            w_dec_seg;
    logic [N_DIGITS-1:0]   w_an_onehot;
    logic [N_DIGITS-1:0]   w_nz_from;

    assign w_tick   = &r_prescaler;
    assign w_pwm_on = (r_prescaler[PRESCALE_W-1 -: 4] <= brightness);

    // w_nz_from[i]: some snapshot nibble at position i or above is non-zero
    always_comb begin
        w_nz_from = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            w_nz_from[i] = |(r_shadow >> (4 * i));
        end
    end

    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_en_sel    = 1'b0;
        w_nz_sel    = 1'b0;
        w_an_onehot = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble       = r_shadow[4*i +: 4];
                w_dp_sel       = dp[i];
                w_en_sel       = digit_en[i];
                w_nz_sel       = w_nz_from[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    assign w_blank = (BLANK_LZ != 0) && (r_idx != '0) && !w_nz_sel && !w_dp_sel;

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler   <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_frame_start <= 1'b0;
            r_disp_seg    <= {7{SEG_INV}};
            r_disp_dp     <= SEG_INV;
            r_disp_an     <= {N_DIGITS{AN_INV}};
        end else begin
            r_prescaler   <= r_prescaler + 1'b1;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                if (r_idx == LAST_IDX) begin
                    r_idx         <= '0;
                    r_shadow      <= value;
                    r_frame_start <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            // Anodes drop out during the tick cycle so the digit change never ghosts
            r_disp_an  <= ((w_en_sel && w_pwm_on && !w_tick) ? w_an_onehot : '0)
                          ^ {N_DIGITS{AN_INV}};
            r_disp_seg <= (w_blank ? SEG_BLANK : w_dec_seg) ^ {7{SEG_INV}};
            r_disp_dp  <= (!w_blank && w_dp_sel) ^ SEG_INV;
        end
    end

    assign disp_seg    = r_disp_seg;
    assign disp_dp     = r_disp_dp;
    assign disp_an     = r_disp_an;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: an active-high instance and an active-low
// instance with digit 2 disabled, checked against a cycle-count based model.
module tb_seg7_scan_driver;

    localparam logic [3:0] EN_B = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [15:0] value;
    logic [3:0]  dp, digit_en, brightness;

    logic [6:0]  a_seg, b_seg;
    logic        a_dp, b_dp, a_fs, b_fs;
    logic [3:0]  a_an, b_an;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS(4), .PRESCALE_W(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LZ(1)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .value(value), .dp(dp), .digit_en(digit_en),
        .brightness(brightness), .disp_seg(a_seg), .disp_dp(a_dp), .disp_an(a_an),
        .frame_start(a_fs)
    );

    seg7_scan_driver #(
        .N_DIGITS(4), .PRESCALE_W(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .value(value), .dp(dp), .digit_en(EN_B),
        .brightness(brightness), .disp_seg(b_seg), .disp_dp(b_dp), .disp_an(b_an),
        .frame_start(b_fs)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {an, dp, seg} (active-high) for the k-th clock after reset release:
    // 16-clock slots, 4 slots per frame, sh = value captured at the last frame boundary.
    function automatic logic [11:0] model_out(input int k, input logic [15:0] sh,
                                              input logic [3:0] en, input logic [3:0] dpv,
                                              input logic [3:0] br);
        int p;
        int d;
        logic blank;
        logic [3:0] an;
        logic [6:0] seg;
        logic dpo;
        p     = k % 16;
        d     = (k / 16) % 4;
        blank = (d != 0) && ((sh >> (4 * d)) == 16'h0) && !dpv[d];
        an    = (en[d] && (p <= int'(br)) && (p != 15)) ? (4'b0001 << d) : 4'b0000;
        seg   = blank ? 7'h00 : hex_tbl[sh[4*d +: 4]];
        dpo   = blank ? 1'b0 : dpv[d];
        return {an, dpo, seg};
    endfunction

    int          ka = 0, kb = 0;
    logic [15:0] sha = '0, shb = '0;
    logic [11:0] ea = '0, eb = '0;
    logic        efa = 1'b0, efb = 1'b0;
    bit          mva = 1'b0, mvb = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            ka = 0; sha = '0; ea = 12'h000; efa = 1'b0; mva = 1'b1;
        end else if (mva) begin
            ea  = model_out(ka, sha, digit_en, dp, brightness);
            efa = (ka % 64 == 63);
            if (efa) sha = value;
            ka++;
        end
        if (rst_b) begin
            kb = 0; shb = '0; eb = 12'hFFF; efb = 1'b0; mvb = 1'b1;
        end else if (mvb) begin
            eb  = ~model_out(kb, shb, EN_B, dp, brightness);
            efb = (kb % 64 == 63);
            if (efb) shb = value;
            kb++;
        end
    end

    always @(negedge clk) begin
        if (mva) begin
            check_eq("model_a_out", {a_an, a_dp, a_seg}, ea);
            check_eq("model_a_fs", a_fs, efa);
        end
        if (mvb) begin
            check_eq("model_b_out", {b_an, b_dp, b_seg}, eb);
            check_eq("model_b_fs", b_fs, efb);
        end
    end

    task automatic wait_frame();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_fs) break;
        end
        check_eq("frame_seen", a_fs, 1);
    endtask

    initial begin
        int cnt;
        int cnt_b;
        rst_a = 1'b1; rst_b = 1'b1;
        value = '0; dp = '0; digit_en = 4'hF; brightness = 4'hF;

        repeat (3) @(negedge clk);
        check_eq("rst_a_an", a_an, 4'h0);
        check_eq("rst_a_seg", {a_dp, a_seg}, 8'h00);
        check_eq("rst_a_fs", a_fs, 0);
        check_eq("rst_b_an", b_an, 4'hF);
        check_eq("rst_b_seg", {b_dp, b_seg}, 8'hFF);
        rst_a = 1'b0; rst_b = 1'b0;

        @(negedge clk);
        check_eq("first_an", a_an, 4'b0001);
        repeat (16) @(negedge clk);
        check_eq("slot1_an", a_an, 4'b0010);
        repeat (48) @(negedge clk);
        check_eq("frame_an", a_an, 4'b0001);

        // Hex decode across all digits, both polarities
        value = 16'h12AF;
        wait_frame();
        @(negedge clk);
        check_eq("s2_d0_seg", a_seg, 7'h71); check_eq("s2_d0_an", a_an, 4'b0001);
        check_eq("s2b_d0_seg", b_seg, 7'h0E); check_eq("s2b_d0_an", b_an, 4'b1110);
        repeat (16) @(negedge clk);
        check_eq("s2_d1_seg", a_seg, 7'h77); check_eq("s2_d1_an", a_an, 4'b0010);
        check_eq("s2b_d1_seg", b_seg, 7'h08); check_eq("s2b_d1_an", b_an, 4'b1101);
        repeat (16) @(negedge clk);
        check_eq("s2_d2_seg", a_seg, 7'h5B); check_eq("s2_d2_an", a_an, 4'b0100);
        check_eq("s2b_d2_seg", b_seg, 7'h24); check_eq("s2b_d2_an", b_an, 4'b1111);
        repeat (16) @(negedge clk);
        check_eq("s2_d3_seg", a_seg, 7'h06); check_eq("s2_d3_an", a_an, 4'b1000);
        check_eq("s2b_d3_seg", b_seg, 7'h79); check_eq("s2b_d3_an", b_an, 4'b0111);
        cnt = 0; cnt_b = 0;
        repeat (128) begin
            @(negedge clk);
            if (a_fs) cnt++;
            if (!b_an[2]) cnt_b++;
        end
        check_eq("fs_per_128", cnt, 2);
        check_eq("b_an2_low", cnt_b, 0);

        // Leading-zero blanking and live dp un-blanking
        value = 16'h0005;
        wait_frame();
        @(negedge clk);
        check_eq("s3_d0_seg", a_seg, 7'h6D);
        repeat (16) @(negedge clk);
        check_eq("s3_d1_blank", {a_dp, a_seg}, 8'h00);
        check_eq("s3_d1_an", a_an, 4'b0010);
        repeat (4) @(negedge clk);
        dp = 4'b0100;
        repeat (12) @(negedge clk);
        check_eq("s3_d2_seg", {a_dp, a_seg}, {1'b1, 7'h3F});
        repeat (16) @(negedge clk);
        check_eq("s3_d3_blank", {a_dp, a_seg}, 8'h00);
        dp = 4'b0000;

        // Mid-frame value change stays invisible until the next snapshot
        value = 16'h1111;
        wait_frame();
        repeat (17) @(negedge clk);
        value = 16'h2222;
        repeat (16) @(negedge clk);
        check_eq("s4_d2_old", a_seg, 7'h06);
        repeat (16) @(negedge clk);
        check_eq("s4_d3_old", a_seg, 7'h06);
        wait_frame();
        @(negedge clk);
        check_eq("s4_d0_new", a_seg, 7'h5B);
        repeat (16) @(negedge clk);
        check_eq("s4_d1_new", a_seg, 7'h5B);

        // PWM duty per slot, including the anti-ghost tick cycle
        brightness = 4'd3;
        wait_frame();
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (a_an[0]) cnt++;
        end
        check_eq("pwm3_count", cnt, 4);
        check_eq("pwm3_tick_an", a_an, 4'b0000);
        brightness = 4'hF;
        wait_frame();
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (a_an[0]) cnt++;
        end
        check_eq("pwm15_count", cnt, 15);
        check_eq("pwm15_tick_an", a_an, 4'b0000);

        // Reset of the active-low instance in the middle of digit 2
        value = 16'h12AF;
        wait_frame();
        repeat (35) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_eq("s6_rst_an", b_an, 4'hF);
        check_eq("s6_rst_seg", {b_dp, b_seg}, 8'hFF);
        check_eq("s6_rst_fs", b_fs, 0);
        rst_b = 1'b0;
        @(negedge clk);
        check_eq("s6_rel_an", b_an, 4'b1110);
        check_eq("s6_rel_seg", b_seg, 7'h40);

        // Random traffic including occasional mid-scan resets
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)  value      = 16'($urandom);
            if ($urandom_range(0, 15) == 0) value      = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)  dp         = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  digit_en   = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  brightness = 4'($urandom);
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 299) == 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
